// File: rtl/item_pkg.sv
`default_nettype none
// ============================================================================
// Module  : item_pkg
// Purpose : Shared item codes, spawner state encoding and LFSR taps.
// Revision: 1.0 - initial release
// ============================================================================
package item_pkg;

    localparam logic [2:0] ITEM_NONE       = 3'd0;
    localparam logic [2:0] ITEM_INVINCIBLE = 3'd1;
    localparam logic [2:0] ITEM_FASTER     = 3'd2;
    localparam logic [2:0] ITEM_FROZEN     = 3'd3;
    localparam logic [2:0] ITEM_LASER      = 3'd4;

    // Galois taps 16,14,13,11 for a right-shifting register.
    localparam logic [15:0] c_LFSR_TAP_MASK = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COOLDOWN = 3'd1,
        ST_DRAW     = 3'd2,
        ST_ARMED    = 3'd3,
        ST_RELEASE  = 3'd4
    } spawn_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        lfsr_next = v[0] ? ((v >> 1) ^ c_LFSR_TAP_MASK) : (v >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/item_lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : item_lfsr16
// Purpose : Free-running 16-bit Galois LFSR, reloaded with seed on reset.
// Revision: 1.0 - initial release
// ============================================================================
module item_lfsr16
    import item_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= seed;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/item_spawner.sv
`default_nettype none
// ============================================================================
// Module  : item_spawner
// Purpose : Places reward items on free grid cells after a cooldown and holds
//           them with set_require until pickup (or timeout when the
//           ITEM_SPAWN_TIMEOUT_EN macro is defined).
// Revision: 1.0 - initial release
// ============================================================================
module item_spawner #(
    parameter int          COOLDOWN_TICKS = 20,
    parameter int          LIFETIME_TICKS = 40,
    parameter int          GRID_W         = 20,
    parameter int          GRID_H         = 15,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_4Hz,
    input  logic       enable,
    input  logic [4:0] mytank_xpos,
    input  logic [4:0] mytank_ypos,
    input  logic       set_finish,
    output logic       set_require,
    output logic [2:0] item_type,
    output logic [4:0] random_xpos,
    output logic [4:0] random_ypos,
    output logic       item_expired
);

    import item_pkg::*;

    localparam logic [7:0] c_COOLDOWN = 8'(COOLDOWN_TICKS);
    localparam logic [5:0] c_GRID_W   = 6'(GRID_W);
    localparam logic [5:0] c_GRID_H   = 6'(GRID_H);

    logic [15:0]  w_lfsr;
    logic [4:0]   w_cand_x;
    logic [4:0]   w_cand_y;
    logic [2:0]   w_cand_type;
    logic         w_cand_ok;
    logic [7:0]   w_cnt_inc;
    logic         w_lfsr_unused;

    spawn_state_t r_state;
    logic [7:0]   r_cnt;
    logic         r_set_require;
    logic [2:0]   r_item_type;
    logic [4:0]   r_xpos;
    logic [4:0]   r_ypos;

    item_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (w_lfsr)
    );

    assign w_cand_x      = w_lfsr[4:0];
    assign w_cand_y      = w_lfsr[9:5];
    assign w_cand_type   = {1'b0, w_lfsr[11:10]} + 3'd1;
    assign w_lfsr_unused = ^w_lfsr[15:12];
    assign w_cnt_inc     = r_cnt + 8'd1;

    // A candidate must lie on the grid and must not land under the player.
    assign w_cand_ok = ({1'b0, w_cand_x} < c_GRID_W) &&
                       ({1'b0, w_cand_y} < c_GRID_H) &&
                       !((w_cand_x == mytank_xpos) && (w_cand_y == mytank_ypos));

`ifdef ITEM_SPAWN_TIMEOUT_EN
    localparam logic [7:0] c_LIFETIME = 8'(LIFETIME_TICKS);
    logic r_item_expired;
    assign item_expired = r_item_expired;
`else
    logic [7:0] w_lifetime_unused;
    assign w_lifetime_unused = 8'(LIFETIME_TICKS);
    assign item_expired      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_set_require <= 1'b0;
            r_item_type   <= ITEM_NONE;
            r_xpos        <= 5'd0;
            r_ypos        <= 5'd0;
`ifdef ITEM_SPAWN_TIMEOUT_EN
            r_item_expired <= 1'b0;
`endif
        end else begin
`ifdef ITEM_SPAWN_TIMEOUT_EN
            r_item_expired <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= 8'd0;
                    r_state <= ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (tick_4Hz) begin
                        if (w_cnt_inc == c_COOLDOWN) begin
                            r_cnt   <= 8'd0;
                            r_state <= ST_DRAW;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_DRAW: begin
                    if (w_cand_ok) begin
                        r_xpos        <= w_cand_x;
                        r_ypos        <= w_cand_y;
                        r_item_type   <= w_cand_type;
                        r_set_require <= 1'b1;
                        r_cnt         <= 8'd0;
                        r_state       <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Pickup is checked first so it beats a same-cycle timeout.
                    if (set_finish) begin
                        r_set_require <= 1'b0;
                        r_item_type   <= ITEM_NONE;
                        r_state       <= ST_RELEASE;
                    end
`ifdef ITEM_SPAWN_TIMEOUT_EN
                    else if (tick_4Hz) begin
                        if (w_cnt_inc == c_LIFETIME) begin
                            r_item_expired <= 1'b1;
                            r_set_require  <= 1'b0;
                            r_item_type    <= ITEM_NONE;
                            r_cnt          <= 8'd0;
                            r_state        <= ST_COOLDOWN;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
`endif
                end
                ST_RELEASE: begin
                    if (!set_finish) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_COOLDOWN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign set_require = r_set_require;
    assign item_type   = r_item_type;
    assign random_xpos = r_xpos;
    assign random_ypos = r_ypos;

endmodule
`default_nettype wire
